// File: rtl/hc595_scan_ctrl.sv
// hc595_scan_ctrl
// Scans a 6-digit seven-segment display that sits behind a 74HC595 chain.
// Each digit slot goes through the same steps:
//   1. Snapshot the slot's value and decimal point.
//   2. Build a 16-bit word {seg, sel}.
//   3. Shift the word out MSB first on ds/shcp.
//   4. Latch it with stcp.
//   5. Hold it for SCAN_CYCLES cycles, then move to the next slot.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   en              scan enable, sampled in IDLE and at HOLD exit
//   dis1..dis6      digit values for slots 0..5
//                   (0-9 numerals, 10 '-', 11-15 blank)
//   dp_mask         per-slot decimal point enable
//   oe_595          595 output enable, active-low
//   shcp_595        595 shift clock
//   stcp_595        595 storage latch clock
//   ds              595 serial data
//   frame_done      one-cycle pulse after slot 5 is latched
// All outputs are registers.
module hc595_scan_ctrl #(
  parameter int CLK_DIV     = 2,
  parameter int SCAN_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] dis1,
  input  logic [3:0] dis2,
  input  logic [3:0] dis3,
  input  logic [3:0] dis4,
  input  logic [3:0] dis5,
  input  logic [3:0] dis6,
  input  logic [5:0] dp_mask,
  output logic       oe_595,
  output logic       shcp_595,
  output logic       stcp_595,
  output logic       ds,
  output logic       frame_done
);

  localparam int CMAX = (CLK_DIV > SCAN_CYCLES) ? CLK_DIV : SCAN_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(SCAN_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, HOLD} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [3:0]     bit_cnt;
  logic [15:0]    word;   // remaining bits; word[15] is the bit on ds
  logic [2:0]     slot;

  logic [3:0]     dig;
  logic           dp;
  logic [7:0]     seg;
  logic [7:0]     sel;
  logic [15:0]    word_new;

  // Pick the current slot's digit and decimal point.
  always_comb begin
    dig = dis1;
    dp  = dp_mask[0];
    case (slot)
      3'd0: begin dig = dis1; dp = dp_mask[0]; end
      3'd1: begin dig = dis2; dp = dp_mask[1]; end
      3'd2: begin dig = dis3; dp = dp_mask[2]; end
      3'd3: begin dig = dis4; dp = dp_mask[3]; end
      3'd4: begin dig = dis5; dp = dp_mask[4]; end
      3'd5: begin dig = dis6; dp = dp_mask[5]; end
      default: ;
    endcase
  end

  // Active-low segment decode: bit 7 is dp, bits 6..0 are g..a.
  always_comb begin
    case (dig)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      4'd10:   seg = 8'hBF;
      default: seg = 8'hFF;
    endcase
    if (dp) seg[7] = 1'b0;
  end

  // Active-low one-hot digit select.
  assign sel      = ~(8'd1 << slot);
  assign word_new = {seg, sel};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      word       <= '0;
      slot       <= '0;
      oe_595     <= 1'b1;
      shcp_595   <= 1'b0;
      stcp_595   <= 1'b0;
      ds         <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          shcp_595 <= 1'b0;
          stcp_595 <= 1'b0;
          ds       <= 1'b0;
          if (en) state <= LOAD;
        end

        // Snapshot the inputs. Present the MSB so it is already valid
        // in the first SHIFT cycle.
        LOAD: begin
          word     <= word_new;
          ds       <= word_new[15];
          shcp_595 <= 1'b0;
          cnt      <= '0;
          bit_cnt  <= '0;
          state    <= SHIFT;
        end

        // Each bit is a low half then a high half on shcp,
        // each half lasting CLK_DIV cycles.
        SHIFT: begin
          if (cnt == DIV_LAST) begin
            cnt <= '0;
            if (!shcp_595) begin
              shcp_595 <= 1'b1;
            end else begin
              shcp_595 <= 1'b0;
              if (bit_cnt == 4'd15) begin
                ds       <= 1'b0;
                stcp_595 <= 1'b1;
                state    <= LATCH;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
                ds      <= word[14];
                word    <= {word[14:0], 1'b0};
              end
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        // stcp falls on entry to HOLD. Outputs turn on at that point
        // and stay on while scanning continues.
        LATCH: begin
          if (cnt == DIV_LAST) begin
            cnt        <= '0;
            stcp_595   <= 1'b0;
            oe_595     <= 1'b0;
            frame_done <= (slot == 3'd5);
            state      <= HOLD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt  <= '0;
            slot <= (slot == 3'd5) ? 3'd0 : slot + 3'd1;
            if (en) begin
              state <= LOAD;
            end else begin
              oe_595 <= 1'b1;
              state  <= IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hc595_scan_ctrl.sv
// Self-checking bench for hc595_scan_ctrl with CLK_DIV=1 and SCAN_CYCLES=4.
// Expected words are queued as stimulus is set up. A monitor rebuilds each
// word from ds on shcp rising edges and compares it on stcp rising edges.
module tb_hc595_scan_ctrl;

  localparam int CLK_DIV     = 1;
  localparam int SCAN_CYCLES = 4;
  localparam int FRAME       = 6 * (1 + 33 * CLK_DIV + SCAN_CYCLES);

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] dis1, dis2, dis3, dis4, dis5, dis6;
  logic [5:0] dp_mask;
  logic       oe_595, shcp_595, stcp_595, ds, frame_done;

  hc595_scan_ctrl #(.CLK_DIV(CLK_DIV), .SCAN_CYCLES(SCAN_CYCLES)) dut (
    .clk(clk), .rst(rst), .en(en),
    .dis1(dis1), .dis2(dis2), .dis3(dis3), .dis4(dis4), .dis5(dis5), .dis6(dis6),
    .dp_mask(dp_mask),
    .oe_595(oe_595), .shcp_595(shcp_595), .stcp_595(stcp_595), .ds(ds),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] sb_q[$];
  int          fd_t[$];
  int          latch_cnt = 0;
  int          bits = 0;
  int          shcp_edges = 0;
  logic [15:0] acc = '0;
  logic        shcp_q = 1'b0;
  logic        stcp_q = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mkword(input logic [3:0] v, input logic dpb, input int slot);
    logic [7:0] s;
    case (v)
      4'd0: s = 8'hC0;  4'd1: s = 8'hF9;  4'd2: s = 8'hA4;  4'd3: s = 8'hB0;
      4'd4: s = 8'h99;  4'd5: s = 8'h92;  4'd6: s = 8'h82;  4'd7: s = 8'hF8;
      4'd8: s = 8'h80;  4'd9: s = 8'h90;  4'd10: s = 8'hBF;
      default: s = 8'hFF;
    endcase
    if (dpb) s[7] = 1'b0;
    return {s, ~(8'd1 << slot)};
  endfunction

  // Queue the expected words for slots lo..hi using the current inputs;
  // v0 overrides slot 0's value.
  task automatic push_slots(input int lo, input int hi, input logic [3:0] v0);
    logic [3:0] v[6];
    v[0] = v0; v[1] = dis2; v[2] = dis3; v[3] = dis4; v[4] = dis5; v[5] = dis6;
    for (int k = lo; k <= hi; k++) sb_q.push_back(mkword(v[k], dp_mask[k], k));
  endtask

  task automatic wait_latch(input int target);
    int g = 0;
    while (latch_cnt < target && g < 2000) begin
      @(negedge clk);
      g++;
    end
    chk("latch_timeout", latch_cnt >= target, 1);
  endtask

  task automatic wait_bits(input int n);
    int g = 0;
    while (bits < n && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk("bits_timeout", bits >= n, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_oe"},   oe_595, 1);
    chk({tag, "_shcp"}, shcp_595, 0);
    chk({tag, "_stcp"}, stcp_595, 0);
    chk({tag, "_ds"},   ds, 0);
    chk({tag, "_fd"},   frame_done, 0);
  endtask

  initial begin
    int e0;
    rst = 1'b1; en = 1'b0;
    dis1 = 4'd3; dis2 = 4'd2; dis3 = 4'd10; dis4 = 4'd10; dis5 = 4'd4; dis6 = 4'd5;
    dp_mask = 6'b000010;

    // Monitor, sampling on the falling edge.
    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          bits = 0;
          acc  = '0;
        end else begin
          if (shcp_595 && !shcp_q) begin
            acc = {acc[14:0], ds};
            bits++;
            shcp_edges++;
          end
          if (stcp_595 && !stcp_q) begin
            chk("shcp_during_latch", shcp_595, 0);
            if (sb_q.size() == 0) begin
              chk("sb_empty", 1, 0);
            end else begin
              chk("word", acc, sb_q.pop_front());
            end
            chk("bit_count", bits, 16);
            bits = 0;
            latch_cnt++;
          end
          if (!stcp_595 && stcp_q) chk("oe_at_stcp_fall", oe_595, 0);
          if (frame_done) fd_t.push_back(cyc);
        end
        shcp_q = shcp_595;
        stcp_q = stcp_595;
      end
    join_none

    // Reset state, then idle with en low.
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    e0 = shcp_edges;
    repeat (100) @(negedge clk);
    chk_reset_outputs("idle");
    chk("idle_shcp_edges", shcp_edges - e0, 0);

    // Frame 1. dis1 changes 3->7 mid-shift of slot 0, so the snapshot
    // keeps B0FE for this frame.
    push_slots(0, 5, 4'd3);
    en = 1'b1;
    wait_bits(5);
    dis1 = 4'd7;
    push_slots(0, 5, 4'd7);  // frame 2
    wait_latch(7);           // frame 2 slot 0 latched
    dis1 = 4'd1;
    push_slots(0, 2, 4'd1);  // frame 3, slots 0..2
    wait_latch(12);
    repeat (3) @(negedge clk);
    chk("fd_count_f2", fd_t.size(), 2);
    if (fd_t.size() >= 2) chk("frame_period", fd_t[1] - fd_t[0], FRAME);

    // Drop en during slot 2's shift: the digit completes, then idle.
    wait_latch(14);
    wait_bits(3);
    en = 1'b0;
    wait_latch(15);
    repeat (10) @(negedge clk);
    chk("en_drop_oe", oe_595, 1);
    e0 = shcp_edges;
    repeat (20) @(negedge clk);
    chk("en_drop_no_shcp", shcp_edges - e0, 0);
    chk("en_drop_latches", latch_cnt, 15);

    // Resume at slot 3.
    push_slots(3, 5, 4'd1);
    en = 1'b1;
    wait_latch(18);
    repeat (3) @(negedge clk);
    chk("fd_count_f3", fd_t.size(), 3);

    // Reset during slot 0's shift at bit 7. The partial word is dropped.
    wait_bits(7);
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_rst");
    repeat (2) @(negedge clk);
    sb_q.push_back(mkword(4'd1, dp_mask[0], 0));
    rst = 1'b0;
    wait_latch(19);
    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
